// File: rtl/collector_ctrl.sv
// Frame sequencer for the collector shift buffer: reads FRAME_LEN samples over a
// rd/rvalid handshake, pushes each one, then advances the frame base by HOP.
module collector_ctrl #(
  parameter int ADDRWIDTH = 20,
  parameter int FRAME_LEN = 100,
  parameter int HOP       = 50,
  parameter int TIMEOUT   = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_cont,
  input  logic                 i_base_load,
  input  logic [ADDRWIDTH-1:0] i_base,
  output logic [ADDRWIDTH-1:0] o_addr,
  output logic                 o_rd,
  input  logic                 i_rvalid,
  input  logic [7:0]           i_data,
  output logic                 o_push,
  output logic [7:0]           o_sample,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [15:0]          o_frame_cnt
);
  // state | meaning
  // IDLE  | waiting for i_start; base may be reloaded
  // REQ   | o_rd high for the current read address
  // WAIT  | waiting for i_rvalid, timeout timer counting down
  // DONE  | o_done pulse; base already advanced by HOP
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [7:0]           LAST_IDX = 8'(FRAME_LEN - 1);
  localparam logic [7:0]           TMR_LOAD = 8'(TIMEOUT - 1);
  localparam logic [ADDRWIDTH-1:0] HOP_INC  = ADDRWIDTH'(HOP);
  localparam logic [ADDRWIDTH-1:0] ONE_INC  = ADDRWIDTH'(1);

  state_t               state_q, state_d;
  logic [ADDRWIDTH-1:0] base_q, base_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [7:0]           scnt_q, scnt_d;
  logic [7:0]           tmr_q, tmr_d;
  logic [7:0]           sample_q, sample_d;
  logic                 rd_q, rd_d;
  logic                 push_q, push_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [15:0]          fcnt_q, fcnt_d;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    addr_d   = addr_q;
    scnt_d   = scnt_q;
    tmr_d    = tmr_q;
    sample_d = sample_q;
    rd_d     = 1'b0;
    push_d   = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    fcnt_d   = fcnt_q;
    if (i_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_base_load) base_d = i_base;
          if (i_start) begin
            state_d = REQ;
            rd_d    = 1'b1;
            scnt_d  = '0;
            err_d   = 1'b0;
            addr_d  = i_base_load ? i_base : base_q;
          end
        end
        REQ: begin
          state_d = WAIT;
          // loaded with TIMEOUT-1 so o_err lands TIMEOUT+1 cycles after o_rd
          tmr_d   = TMR_LOAD;
        end
        WAIT: begin
          if (i_rvalid) begin
            push_d   = 1'b1;
            sample_d = i_data;
            addr_d   = addr_q + ONE_INC;
            scnt_d   = scnt_q + 8'd1;
            if (scnt_q == LAST_IDX) begin
              state_d = DONE;
              done_d  = 1'b1;
              base_d  = base_q + HOP_INC;
              fcnt_d  = fcnt_q + 16'd1;
            end else begin
              state_d = REQ;
              rd_d    = 1'b1;
            end
          end else if (tmr_q == 8'd0) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            tmr_d = tmr_q - 8'd1;
          end
        end
        DONE: begin
          if (i_cont) begin
            state_d = REQ;
            rd_d    = 1'b1;
            addr_d  = base_q;
            scnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      scnt_q   <= '0;
      tmr_q    <= '0;
      sample_q <= '0;
      rd_q     <= 1'b0;
      push_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
      scnt_q   <= scnt_d;
      tmr_q    <= tmr_d;
      sample_q <= sample_d;
      rd_q     <= rd_d;
      push_q   <= push_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign o_addr      = addr_q;
  assign o_rd        = rd_q;
  assign o_push      = push_q;
  assign o_sample    = sample_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_frame_cnt = fcnt_q;

endmodule

// File: tb/tb_collector_ctrl.sv
// Directed bench for collector_ctrl: behavioural memory responder, output
// monitor recording reads/pushes/dones, and one task per scenario.
`timescale 1ns/1ps
module tb_collector_ctrl;
  localparam int AW = 20;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start, i_abort, i_cont, i_base_load;
  logic [AW-1:0] i_base, o_addr;
  logic          o_rd, i_rvalid, o_push, o_busy, o_done, o_err;
  logic [7:0]    i_data, o_sample;
  logic [15:0]   o_frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [AW-1:0] rd_addr_q[$];
  int            rd_cyc_q[$];
  logic [7:0]    push_q[$];
  int            push_cyc_q[$];
  int            done_cyc_q[$];
  int            busy_fall_cyc = -1;
  int            err_rise_cyc = -1;

  logic          stall_en = 1'b0;
  logic          dead_en = 1'b0;
  logic [AW-1:0] stall_addr = '0;
  logic [AW-1:0] dead_addr = '0;

  collector_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_cont(i_cont), .i_base_load(i_base_load), .i_base(i_base),
    .o_addr(o_addr), .o_rd(o_rd), .i_rvalid(i_rvalid), .i_data(i_data),
    .o_push(o_push), .o_sample(o_sample), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_frame_cnt(o_frame_cnt)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // memory: data = addr[7:0], latency 1 (4 on stall_addr, never on dead_addr)
  initial begin : mem_model
    logic [AW-1:0] a;
    int lat;
    i_rvalid = 1'b0;
    i_data   = '0;
    @(posedge i_clk); #1;
    forever begin
      if (o_rd === 1'b1 && !(dead_en && o_addr == dead_addr)) begin
        a   = o_addr;
        lat = (stall_en && a == stall_addr) ? 4 : 1;
        repeat (lat) begin @(posedge i_clk); #1; end
        i_rvalid = 1'b1;
        i_data   = a[7:0];
        @(posedge i_clk); #1;
        i_rvalid = 1'b0;
      end else begin
        @(posedge i_clk); #1;
      end
    end
  end

  initial begin : monitor
    logic prev_busy, prev_err;
    prev_busy = 1'b0;
    prev_err  = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      if (o_rd === 1'b1) begin rd_addr_q.push_back(o_addr); rd_cyc_q.push_back(cyc); end
      if (o_push === 1'b1) begin push_q.push_back(o_sample); push_cyc_q.push_back(cyc); end
      if (o_done === 1'b1) done_cyc_q.push_back(cyc);
      if (prev_busy === 1'b1 && o_busy === 1'b0) busy_fall_cyc = cyc;
      if (prev_err === 1'b0 && o_err === 1'b1) err_rise_cyc = cyc;
      prev_busy = o_busy;
      prev_err  = o_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge i_clk); #2; end
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    tick(2);
    i_rst = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    #1 i_rst = 1'b0;
    #1;
    checks++;
    if ({o_rd, o_push, o_busy, o_done, o_err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {o_rd, o_push, o_busy, o_done, o_err});
    end
    checks++;
    if (o_addr !== '0 || o_sample !== 8'h00 || o_frame_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_values: addr %0h sample %0h cnt %0h expected all 0", o_addr, o_sample, o_frame_cnt);
    end
    tick(2);
    i_rst = 1'b1;
    tick(2);
    checks++;
    if (o_busy !== 1'b0 || o_rd !== 1'b0) begin
      errors++; $display("FAIL reset_release_idle: busy %b rd %b expected 0 0", o_busy, o_rd);
    end
  endtask

  task automatic test_single_frame();
    int r0, p0, d0, k;
    r0 = rd_addr_q.size(); p0 = push_q.size(); d0 = done_cyc_q.size();
    k = cyc + 1;
    i_start = 1'b1; tick(1); i_start = 1'b0;
    tick(215);
    checks++;
    if (rd_cyc_q.size() <= r0 || rd_cyc_q[r0] != k) begin
      errors++; $display("FAIL single_rd_latency: first rd cycle %0d expected %0d", (rd_cyc_q.size() > r0) ? rd_cyc_q[r0] : -1, k);
    end
    checks++;
    if (push_q.size() - p0 != 100) begin
      errors++; $display("FAIL single_push_count: got %0d expected 100", push_q.size() - p0);
    end
    for (int n = 0; n < 100; n++) begin
      checks++;
      if (push_q[p0+n] !== 8'(n) || push_cyc_q[p0+n] != k + 2 + 2*n || rd_addr_q[r0+n] !== AW'(n)) begin
        errors++;
        $display("FAIL single_sample_%0d: sample %0h cyc %0d addr %0h expected %0h %0d %0h",
                 n, push_q[p0+n], push_cyc_q[p0+n], rd_addr_q[r0+n], n, k + 2 + 2*n, n);
        break;
      end
    end
    checks++;
    if (done_cyc_q.size() - d0 != 1 || done_cyc_q[d0] != k + 200) begin
      errors++; $display("FAIL single_done: count %0d cycle %0d expected 1 at %0d", done_cyc_q.size() - d0, done_cyc_q[d0], k + 200);
    end
    checks++;
    if (busy_fall_cyc != k + 201) begin
      errors++; $display("FAIL single_busy_fall: got %0d expected %0d", busy_fall_cyc, k + 201);
    end
    checks++;
    if (o_frame_cnt !== 16'd1) begin
      errors++; $display("FAIL single_frame_cnt: got %0d expected 1", o_frame_cnt);
    end
    // next frame must start from base 50, then abort it in REQ
    p0 = push_q.size();
    i_start = 1'b1; tick(1); i_start = 1'b0;
    checks++;
    if (o_rd !== 1'b1 || o_addr !== AW'(50)) begin
      errors++; $display("FAIL single_next_base: rd %b addr %0h expected 1 32", o_rd, o_addr);
    end
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_rd !== 1'b0) begin
      errors++; $display("FAIL abort_req_idle: busy %b rd %b expected 0 0", o_busy, o_rd);
    end
    tick(4);
    checks++;
    if (push_q.size() != p0 || o_frame_cnt !== 16'd1) begin
      errors++; $display("FAIL abort_req_effects: pushes %0d cnt %0d expected 0 1", push_q.size() - p0, o_frame_cnt);
    end
  endtask

  task automatic test_cont();
    int r0, d0, k, fail_i;
    do_reset();
    r0 = rd_addr_q.size(); d0 = done_cyc_q.size();
    k = cyc + 1;
    i_cont = 1'b1; i_start = 1'b1; tick(1); i_start = 1'b0;
    for (int i = 0; i < 1000 && done_cyc_q.size() - d0 < 2; i++) tick(1);
    checks++;
    if (done_cyc_q.size() - d0 < 2) begin
      errors++; $display("FAIL cont_timeout: dones %0d expected 2 within budget", done_cyc_q.size() - d0);
    end
    tick(1);
    i_cont = 1'b0;
    tick(220);
    checks++;
    if (rd_addr_q.size() - r0 != 300 || done_cyc_q.size() - d0 != 3) begin
      errors++; $display("FAIL cont_counts: reads %0d dones %0d expected 300 3", rd_addr_q.size() - r0, done_cyc_q.size() - d0);
    end
    fail_i = -1;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 100; i++)
        if (fail_i < 0 && rd_addr_q[r0 + 100*f + i] !== AW'(50*f + i)) fail_i = 100*f + i;
    checks++;
    if (fail_i >= 0) begin
      errors++; $display("FAIL cont_addr: read %0d addr %0h expected %0h", fail_i, rd_addr_q[r0+fail_i], 50*(fail_i/100) + fail_i%100);
    end
    for (int f = 0; f < 3; f++) begin
      checks++;
      if (done_cyc_q[d0+f] != k + 200 + 201*f) begin
        errors++; $display("FAIL cont_done_%0d: cycle %0d expected %0d", f, done_cyc_q[d0+f], k + 200 + 201*f);
      end
    end
    for (int f = 1; f < 3; f++) begin
      checks++;
      if (rd_cyc_q[r0 + 100*f] != done_cyc_q[d0+f-1] + 1) begin
        errors++; $display("FAIL cont_gap_%0d: rd at %0d expected %0d", f, rd_cyc_q[r0 + 100*f], done_cyc_q[d0+f-1] + 1);
      end
    end
    checks++;
    if (o_frame_cnt !== 16'd3 || o_busy !== 1'b0) begin
      errors++; $display("FAIL cont_end: cnt %0d busy %b expected 3 0", o_frame_cnt, o_busy);
    end
  endtask

  task automatic test_wrap();
    int r0, p0, fail_i;
    logic [AW-1:0] ea;
    r0 = rd_addr_q.size(); p0 = push_q.size();
    i_base = 20'hFFFF6; i_base_load = 1'b1; i_start = 1'b1; tick(1);
    i_base_load = 1'b0; i_start = 1'b0;
    tick(215);
    checks++;
    if (rd_addr_q.size() - r0 != 100 || push_q.size() - p0 != 100) begin
      errors++; $display("FAIL wrap_counts: reads %0d pushes %0d expected 100 100", rd_addr_q.size() - r0, push_q.size() - p0);
    end
    fail_i = -1;
    for (int i = 0; i < 100; i++) begin
      ea = 20'hFFFF6 + AW'(i);
      if (fail_i < 0 && (rd_addr_q[r0+i] !== ea || push_q[p0+i] !== ea[7:0])) fail_i = i;
    end
    checks++;
    if (fail_i >= 0) begin
      errors++; $display("FAIL wrap_addr: index %0d addr %0h sample %0h", fail_i, rd_addr_q[r0+fail_i], push_q[p0+fail_i]);
    end
    checks++;
    if (rd_addr_q[r0+9] !== 20'hFFFFF || rd_addr_q[r0+10] !== 20'h00000) begin
      errors++; $display("FAIL wrap_edge: got %0h %0h expected fffff 0", rd_addr_q[r0+9], rd_addr_q[r0+10]);
    end
    checks++;
    if (o_frame_cnt !== 16'd4) begin
      errors++; $display("FAIL wrap_frame_cnt: got %0d expected 4", o_frame_cnt);
    end
    i_start = 1'b1; tick(1); i_start = 1'b0;
    checks++;
    if (o_rd !== 1'b1 || o_addr !== 20'h00028) begin
      errors++; $display("FAIL wrap_next_base: rd %b addr %0h expected 1 28", o_rd, o_addr);
    end
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
    tick(3);
  endtask

  task automatic test_timeout();
    int r0, p0, d0;
    do_reset();
    stall_en = 1'b1; stall_addr = AW'(40);
    dead_en  = 1'b1; dead_addr  = AW'(60);
    r0 = rd_addr_q.size(); p0 = push_q.size(); d0 = done_cyc_q.size();
    i_start = 1'b1; tick(1); i_start = 1'b0;
    tick(300);
    checks++;
    if (push_q.size() - p0 != 60 || push_q[push_q.size()-1] !== 8'd59) begin
      errors++; $display("FAIL timeout_pushes: count %0d last %0h expected 60 3b", push_q.size() - p0, push_q[push_q.size()-1]);
    end
    checks++;
    if (push_cyc_q[p0+40] != rd_cyc_q[r0+40] + 5) begin
      errors++; $display("FAIL timeout_stall: push at %0d expected %0d", push_cyc_q[p0+40], rd_cyc_q[r0+40] + 5);
    end
    checks++;
    if (rd_addr_q.size() - r0 != 61 || err_rise_cyc != rd_cyc_q[r0+60] + 16) begin
      errors++; $display("FAIL timeout_err_time: reads %0d err at %0d expected 61 at %0d", rd_addr_q.size() - r0, err_rise_cyc, rd_cyc_q[r0+60] + 16);
    end
    checks++;
    if (busy_fall_cyc != err_rise_cyc || o_err !== 1'b1) begin
      errors++; $display("FAIL timeout_busy: fall %0d err %b expected %0d 1", busy_fall_cyc, o_err, err_rise_cyc);
    end
    checks++;
    if (done_cyc_q.size() != d0 || o_frame_cnt !== 16'd0) begin
      errors++; $display("FAIL timeout_no_done: dones %0d cnt %0d expected 0 0", done_cyc_q.size() - d0, o_frame_cnt);
    end
    stall_en = 1'b0; dead_en = 1'b0;
    i_start = 1'b1; tick(1); i_start = 1'b0;
    checks++;
    if (o_rd !== 1'b1 || o_addr !== '0 || o_err !== 1'b0) begin
      errors++; $display("FAIL timeout_restart: rd %b addr %0h err %b expected 1 0 0", o_rd, o_addr, o_err);
    end
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
    tick(3);
  endtask

  task automatic test_abort_rvalid();
    int r0, p0, d0;
    r0 = rd_addr_q.size(); p0 = push_q.size(); d0 = done_cyc_q.size();
    i_start = 1'b1; tick(1); i_start = 1'b0;
    for (int i = 0; i < 200 && rd_addr_q.size() - r0 < 21; i++) tick(1);
    checks++;
    if (rd_addr_q.size() - r0 != 21) begin
      errors++; $display("FAIL abort_wait: reads %0d expected 21 within budget", rd_addr_q.size() - r0);
    end
    tick(1);
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
    checks++;
    if (o_push !== 1'b0 || o_busy !== 1'b0 || o_rd !== 1'b0) begin
      errors++; $display("FAIL abort_rvalid_next: push %b busy %b rd %b expected 0 0 0", o_push, o_busy, o_rd);
    end
    tick(5);
    checks++;
    if (push_q.size() - p0 != 20 || done_cyc_q.size() != d0 || o_frame_cnt !== 16'd0) begin
      errors++; $display("FAIL abort_rvalid_effects: pushes %0d dones %0d cnt %0d expected 20 0 0", push_q.size() - p0, done_cyc_q.size() - d0, o_frame_cnt);
    end
  endtask

  task automatic test_busy_ignore_and_reset();
    int r0, fail_i, seen;
    do_reset();
    r0 = rd_addr_q.size();
    i_start = 1'b1; tick(1); i_start = 1'b0;
    tick(31);
    i_base = 20'h12345; i_base_load = 1'b1; i_start = 1'b1; tick(1);
    i_base_load = 1'b0; i_start = 1'b0;
    tick(200);
    fail_i = -1;
    for (int i = 0; i < 100; i++)
      if (fail_i < 0 && rd_addr_q[r0+i] !== AW'(i)) fail_i = i;
    checks++;
    if (rd_addr_q.size() - r0 != 100 || fail_i >= 0 || o_frame_cnt !== 16'd1) begin
      errors++; $display("FAIL busy_ignore_frame: reads %0d bad index %0d cnt %0d expected 100 -1 1", rd_addr_q.size() - r0, fail_i, o_frame_cnt);
    end
    i_start = 1'b1; tick(1); i_start = 1'b0;
    checks++;
    if (o_addr !== AW'(50)) begin
      errors++; $display("FAIL busy_ignore_base: addr %0h expected 32", o_addr);
    end
    tick(20);
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      if (o_rd === 1'b1) seen = 1; else tick(1);
    end
    checks++;
    if (seen == 0) begin
      errors++; $display("FAIL rst_wait_rd: no rd seen within budget");
    end
    #3 i_rst = 1'b0;
    #1;
    checks++;
    if ({o_rd, o_push, o_busy, o_done, o_err} !== 5'b0 || o_addr !== '0 || o_sample !== 8'h00 || o_frame_cnt !== 16'h0) begin
      errors++;
      $display("FAIL rst_midframe: flags %b addr %0h sample %0h cnt %0d expected 0", {o_rd, o_push, o_busy, o_done, o_err}, o_addr, o_sample, o_frame_cnt);
    end
    tick(2);
    i_rst = 1'b1;
    tick(1);
    i_start = 1'b1; tick(1); i_start = 1'b0;
    checks++;
    if (o_rd !== 1'b1 || o_addr !== '0) begin
      errors++; $display("FAIL rst_restart: rd %b addr %0h expected 1 0", o_rd, o_addr);
    end
    i_abort = 1'b1; tick(1); i_abort = 1'b0;
    tick(3);
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_cont = 1'b0;
    i_base_load = 1'b0; i_base = '0;
    test_reset();
    test_single_frame();
    test_cont();
    test_wrap();
    test_timeout();
    test_abort_rvalid();
    test_busy_ignore_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
